// File: rtl/md_sequencer_if.sv
// Multiply/divide sequencer bus: request, MTHI/MTLO writes, ALU hookup, HI/LO.
// master = execute-stage side (also owns the ALU result), slave = sequencer.
interface md_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_f;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b,
    output hi_we, lo_we, wdata, alu_y,
    input  alu_a, alu_b, alu_f,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    input  hi_we, lo_we, wdata, alu_y,
    output alu_a, alu_b, alu_f,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// Iterative MULTU/DIVU (MULT/DIV with MD_SIGNED_EN) over the shared ALU.
// Owns HI/LO. Signed fixup state exists only when MD_SIGNED_EN is defined.
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave md
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE, RUN, FIX, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
`ifdef MD_SIGNED_EN
  logic             sgn_q, sgn_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
`else
  logic             unused_op1;
  assign unused_op1 = md.op[1];
`endif

  logic [WIDTH-1:0] a_mag, b_mag, s;
  logic             carry, ge;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    md.alu_a = '0;
    md.alu_b = '0;
    md.alu_f = 3'b010;
    a_mag    = md.src_a;
    b_mag    = md.src_b;
`ifdef MD_SIGNED_EN
    sgn_d    = sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    if (md.op[1]) begin
      if (md.src_a[WIDTH-1]) a_mag = -md.src_a;
      if (md.src_b[WIDTH-1]) b_mag = -md.src_b;
    end
`endif
    s     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    carry = md.alu_y < hi_q;
    ge    = hi_q[WIDTH-1] | (s >= opnd_q);

    unique case (state_q)
      IDLE: begin
        if (md.start) begin
          state_d = RUN;
          cnt_d   = '0;
          hi_d    = '0;
          div_d   = md.op[0];
          lo_d    = md.op[0] ? a_mag : b_mag;
          opnd_d  = md.op[0] ? b_mag : a_mag;
`ifdef MD_SIGNED_EN
          sgn_d   = md.op[1];
          sa_d    = md.op[1] & md.src_a[WIDTH-1];
          sb_d    = md.op[1] & md.src_b[WIDTH-1];
`endif
        end else begin
          if (md.hi_we) hi_d = md.wdata;
          if (md.lo_we) lo_d = md.wdata;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          md.alu_a = s;
          md.alu_b = opnd_q;
          md.alu_f = 3'b110;
          hi_d     = ge ? md.alu_y : s;
          lo_d     = {lo_q[WIDTH-2:0], ge};
        end else begin
          md.alu_a = hi_q;
          md.alu_b = lo_q[0] ? opnd_q : '0;
          hi_d     = {carry, md.alu_y[WIDTH-1:1]};
          lo_d     = {md.alu_y[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1)) begin
`ifdef MD_SIGNED_EN
          state_d = sgn_q ? FIX : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MD_SIGNED_EN
      FIX: begin
        state_d = DONE;
        if (div_q) begin
          // Remainder follows the dividend's sign.
          if (sa_q ^ sb_q) lo_d = -lo_q;
          if (sa_q)        hi_d = -hi_q;
        end else if (sa_q ^ sb_q) begin
          {hi_d, lo_d} = -{hi_q, lo_q};
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
`ifdef MD_SIGNED_EN
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
`ifdef MD_SIGNED_EN
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`endif
    end
  end

  assign md.busy = (state_q != IDLE);
  assign md.done = (state_q == DONE);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with a behavioural add/sub ALU.
// Works with and without MD_SIGNED_EN.
module tb_md_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   lat;
  logic busy_all;

  always #5 clk = ~clk;

  md_sequencer_if #(.WIDTH(32)) md ();

  assign md.alu_y = (md.alu_f == 3'b110) ?
                    md.alu_a - md.alu_b :
                    md.alu_a + md.alu_b;

  md_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Drive a request for one cycle; returns at the negedge of cycle k+1.
  task automatic kick(input logic [1:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    md.start = 1'b1;
    md.op    = op;
    md.src_a = a;
    md.src_b = b;
    @(negedge clk);
    md.start = 1'b0;
    md.src_a = 32'h0;
    md.src_b = 32'h0;
    lat      = 1;
    busy_all = md.busy;
  endtask

  // Bounded wait for done; lat counts cycles since the accepting edge.
  task automatic wait_done();
    while (!md.done && lat < 45) begin
      @(negedge clk);
      lat++;
      busy_all &= md.busy;
    end
  endtask

  task automatic run(input string tag,
                     input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int exp_lat,
                     input logic [31:0] exp_hi,
                     input logic [31:0] exp_lo);
    kick(op, a, b);
    wait_done();
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy_all, 1'b1);
    check({tag, "_hi"}, md.hi, exp_hi);
    check({tag, "_lo"}, md.lo, exp_lo);
    @(negedge clk);
    check({tag, "_idle"}, md.busy, 1'b0);
  endtask

  initial begin
    md.start = 1'b0;
    md.op    = 2'b00;
    md.src_a = 32'h0;
    md.src_b = 32'h0;
    md.hi_we = 1'b0;
    md.lo_we = 1'b0;
    md.wdata = 32'h0;
    reset    = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_hi", md.hi, 32'h0);
    check("rst_lo", md.lo, 32'h0);
    check("rst_busy", md.busy, 1'b0);
    check("rst_done", md.done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("idle_alu_a", md.alu_a, 32'h0);
    check("idle_alu_f", md.alu_f, 32'h2);

    run("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
        33, 32'hFFFFFFFE, 32'h00000001);
    run("divu_100_7", 2'b01, 32'd100, 32'd7,
        33, 32'd2, 32'd14);
    run("divu_msb_3", 2'b01, 32'h80000000, 32'd3,
        33, 32'd2, 32'h2AAAAAAA);
    run("divu_by0", 2'b01, 32'h12345678, 32'h0,
        33, 32'h12345678, 32'hFFFFFFFF);

    // Second start and MTHI while busy must both be dropped.
    kick(2'b01, 32'd100, 32'd7);
    check("run_alu_f", md.alu_f, 32'h6);
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    md.start = 1'b1;
    md.op    = 2'b00;
    md.src_a = 32'd3;
    md.src_b = 32'd3;
    @(negedge clk);
    lat++;
    md.start = 1'b0;
    md.hi_we = 1'b1;
    md.wdata = 32'h0000DEAD;
    @(negedge clk);
    lat++;
    md.hi_we = 1'b0;
    wait_done();
    check("ign_lat", lat, 33);
    check("ign_hi", md.hi, 32'd2);
    check("ign_lo", md.lo, 32'd14);
    @(negedge clk);

    // Reset mid-operation, then MTLO in the first cycle after release.
    kick(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_hi", md.hi, 32'h0);
    check("mid_rst_lo", md.lo, 32'h0);
    check("mid_rst_busy", md.busy, 1'b0);
    @(negedge clk);
    reset    = 1'b0;
    md.lo_we = 1'b1;
    md.wdata = 32'h55;
    @(negedge clk);
    md.lo_we = 1'b0;
    check("mtlo_lo", md.lo, 32'h55);
    check("mtlo_hi", md.hi, 32'h0);

    md.hi_we = 1'b1;
    md.lo_we = 1'b1;
    md.wdata = 32'hA5;
    @(negedge clk);
    md.hi_we = 1'b0;
    md.lo_we = 1'b0;
    check("mtboth_hi", md.hi, 32'hA5);
    check("mtboth_lo", md.lo, 32'hA5);

    // Start beats a simultaneous MTHI.
    md.hi_we = 1'b1;
    md.wdata = 32'h77;
    kick(2'b01, 32'd100, 32'd7);
    md.hi_we = 1'b0;
    check("st_wins_hi", md.hi, 32'h0);
    wait_done();
    check("st_wins_q", md.lo, 32'd14);
    @(negedge clk);

`ifdef MD_SIGNED_EN
    run("mult_m3_5", 2'b10, 32'hFFFFFFFD, 32'd5,
        34, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2,
        34, 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
    run("mult_uns", 2'b10, 32'hFFFFFFFD, 32'd5,
        33, 32'h4, 32'hFFFFFFF1);
    run("div_uns", 2'b11, 32'hFFFFFFF9, 32'd2,
        33, 32'h1, 32'h7FFFFFFC);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
